ysyx_22040088_ifu: RTL and testbench

- Instruction fetch unit for the single-issue RV64 NPC core.
- Holds the architectural PC and issues one 32-bit fetch per instruction over a valid/ready request / valid response memory port.
- Registers the fetched instruction with its PC and presents it downstream to the decode stage through a valid/ready handshake.
- Accepts PC redirects from the execute stage (jumps, taken branches) and squashes any in-flight or held fetch.

---
 rtl/ysyx_22040088_ifu_pkg.sv | 20 ++
 rtl/ysyx_22040088_pcreg.sv | 33 +++
 rtl/ysyx_22040088_ifu.sv | 139 +++++++++++++
 tb/tb_ysyx_22040088_ifu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared constants and encodings for the NPC instruction fetch unit.
package ysyx_22040088_ifu_pkg;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/ysyx_22040088_pcreg.sv
// Architectural PC register with hold / sequential / redirect next-PC select.
module ysyx_22040088_pcreg
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter int                XLEN     = ysyx_22040088_ifu_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(ysyx_22040088_ifu_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:   pc_d = pc_q + XLEN'(4);
      PC_REDIR: pc_d = redirect_pc;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Fetch FSM: issue one imem request per instruction, hold the result for decode,
// and squash in-flight fetches on execute-stage redirects.
module ysyx_22040088_ifu
  import ysyx_22040088_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = ysyx_22040088_ifu_pkg::RESET_PC,
  parameter int          XLEN     = ysyx_22040088_ifu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misalign
);

  ifu_state_e      state_d, state_q;
  logic            drop_d, drop_q;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc;

  logic            if_valid_d, if_valid_q;
  logic [31:0]     if_inst_d, if_inst_q;
  logic [XLEN-1:0] if_pc_d, if_pc_q;
  logic            if_misalign_d, if_misalign_q;

  logic pc_misalign, req_fire;

  ysyx_22040088_pcreg #(
    .XLEN     (XLEN),
    .RESET_PC (XLEN'(RESET_PC))
  ) u_pcreg (
    .clk         (clk),
    .rst         (rst),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  assign pc_misalign    = pc[1:0] != 2'b00;
  // Gated by reset so nothing is presented to memory while held in reset.
  assign imem_req_valid = rst && (state_q == S_REQ) && !pc_misalign;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    pc_sel        = PC_HOLD;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    if_misalign_d = if_misalign_q;
    case (state_q)
      S_REQ: begin
        if (pc_misalign) begin
          if_valid_d    = 1'b1;
          if_inst_d     = NOP;
          if_pc_d       = pc;
          if_misalign_d = 1'b1;
          state_d       = S_HOLD;
        end else if (req_fire) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
          if (redirect_valid) pc_sel = PC_REDIR;
        end else if (redirect_valid) begin
          pc_sel = PC_REDIR;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_sel = PC_REDIR;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_valid_d    = 1'b1;
            if_inst_d     = imem_rsp_data;
            if_pc_d       = pc;
            if_misalign_d = 1'b0;
            state_d       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect squashes the held instruction even if decode takes it.
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          pc_sel     = PC_REDIR;
          state_d    = S_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          pc_sel     = PC_INC;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_REQ;
      drop_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP;
      if_pc_q       <= '0;
      if_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      if_misalign_q <= if_misalign_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign if_misalign = if_misalign_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Directed bench for the fetch unit: handshake, stall, redirect squash,
// misaligned redirect and mid-fetch reset.
module tb_ysyx_22040088_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        if_misalign;

  int n_vec = 0;
  int n_err = 0;

  ysyx_22040088_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  // A response while decode is holding an instruction breaks the memory protocol.
  always @(posedge clk)
    if (rst) assert (!(imem_rsp_valid && if_valid)) else $error("imem response while holding");

  initial begin
    #100000;
    $display("FAIL timeout n_vec=%0d", n_vec);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_reqv"}, imem_req_valid, 0);
    chk({tag, "_ifv"},  if_valid, 0);
    chk({tag, "_inst"}, if_inst, 64'h13);
    chk({tag, "_pc"},   if_pc, 0);
    chk({tag, "_mis"},  if_misalign, 0);
  endtask

  // One accepted request followed by a 1-cycle response; ends in S_HOLD.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    tick();
    tick();
    chk_reset_outs("rst");

    // basic fetch with decode ready
    rst = 1'b1;
    #1;
    chk("t1_reqv", imem_req_valid, 1);
    chk("t1_addr", imem_req_addr, 64'h8000_0000);
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t1_wait_reqv", imem_req_valid, 0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0297;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t1_ifv",  if_valid, 1);
    chk("t1_ifpc", if_pc, 64'h8000_0000);
    chk("t1_inst", if_inst, 64'h0000_0297);
    chk("t1_mis",  if_misalign, 0);
    tick();
    chk("t1_ifv0",  if_valid, 0);
    chk("t1_reqv2", imem_req_valid, 1);
    chk("t1_addr2", imem_req_addr, 64'h8000_0004);

    // decode stall for 5 cycles
    if_ready = 1'b0;
    fetch(32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      chk("t2_ifv",  if_valid, 1);
      chk("t2_inst", if_inst, 64'h0010_0093);
      chk("t2_ifpc", if_pc, 64'h8000_0004);
      chk("t2_reqv", imem_req_valid, 0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("t2_ifv0", if_valid, 0);
    chk("t2_reqv", imem_req_valid, 1);
    chk("t2_addr", imem_req_addr, 64'h8000_0008);

    // redirect while waiting; late response must be dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_reqv_w", imem_req_valid, 0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t3_ifv",  if_valid, 0);
    chk("t3_inst", if_inst, 64'h0010_0093);
    chk("t3_reqv", imem_req_valid, 1);
    chk("t3_addr", imem_req_addr, 64'h8000_0100);

    // redirect and decode-ready in the same hold cycle
    fetch(32'h0000_0513);
    chk("t4_ifv",  if_valid, 1);
    chk("t4_ifpc", if_pc, 64'h8000_0100);
    chk("t4_inst", if_inst, 64'h0000_0513);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    chk("t4_ifv0", if_valid, 0);
    chk("t4_reqv", imem_req_valid, 1);
    chk("t4_addr", imem_req_addr, 64'h8000_0200);

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0302;
    tick();
    redirect_valid = 1'b0;
    chk("t5_reqv", imem_req_valid, 0);
    tick();
    chk("t5_ifv",  if_valid, 1);
    chk("t5_mis",  if_misalign, 1);
    chk("t5_inst", if_inst, 64'h13);
    chk("t5_ifpc", if_pc, 64'h8000_0302);
    chk("t5_reqv2", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    tick();
    redirect_valid = 1'b0;
    chk("t5_ifv0", if_valid, 0);
    chk("t5_addr", imem_req_addr, 64'h8000_0400);

    // reset asserted during S_WAIT, stale response straddles release
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outs("t6_rst");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    rst = 1'b1;
    #1;
    chk("t6_reqv", imem_req_valid, 1);
    chk("t6_addr", imem_req_addr, 64'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    chk("t6_ifv",   if_valid, 0);
    chk("t6_inst",  if_inst, 64'h13);
    chk("t6_reqv2", imem_req_valid, 1);
    chk("t6_addr2", imem_req_addr, 64'h8000_0000);
    fetch(32'h0000_0297);
    chk("t6_ifv1",  if_valid, 1);
    chk("t6_ifpc",  if_pc, 64'h8000_0000);
    chk("t6_inst2", if_inst, 64'h0000_0297);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
